pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
// - Parametrised, elastic pipeline-stage register for the CPU kernel: generalises the fixed EXE->MEM latch
//   to any payload width, with valid/ready handshake, optional skid entry, flush and stall-cycle counter.
// - Sits between two pipeline stages (first use: EXE->MEM); payload is an opaque packed bus.
// PARAMETERS
// - DATA_W   160  payload width in bits (>=1)
// - SKID_EN  1    1: two-entry skid buffer, up_ready_o registered; 0: single entry, up_ready_o combinational
// - CNT_W    16   width of stall-cycle counter (>=1)
// PORTS
// - clk_i         in   1       clock, all state on rising edge
// - rst_i         in   1       reset, asynchronous, active-high
// - flush_i       in   1       synchronous kill of all held entries
// - up_valid_i    in   1       upstream payload valid
// - up_ready_o    out  1       stage can accept payload this cycle
// - up_data_i     in   DATA_W  upstream payload
// - down_valid_o  out  1       main entry holds valid payload
// - down_ready_i  in   1       downstream accepts main entry this cycle
// - down_data_o   out  DATA_W  main entry payload
// - clr_cnt_i     in   1       synchronous clear of stall counter
// - stall_cnt_o   out  CNT_W   saturating count of cycles with down_valid_o & !down_ready_i
// - occ_o         out  2       entries held: 0,1,2 (2 only when SKID_EN=1)
// BEHAVIOUR
// - Reset (async): state EMPTY; down_valid_o=0, down_data_o=0, skid data=0, stall_cnt_o=0, occ_o=0;
//   up_ready_o=1 (SKID_EN=1) / =1 while empty (SKID_EN=0).
// - Transfers: up_fire = up_valid_i & up_ready_o; down_fire = down_valid_o & down_ready_i. Latency 1 cycle
//   from up_fire to down_valid_o when stage empty or draining.
// - States (SKID_EN=1): EMPTY(occ 0), FULL(occ 1), SKID(occ 2). up_ready_o = (state != SKID), registered.
//   EMPTY: up_fire -> FULL, main<=up_data_i; else stay.
//   FULL : up_fire&down_fire -> FULL, main<=up_data_i; !up_fire&down_fire -> EMPTY;
//          up_fire&!down_fire -> SKID, skid<=up_data_i, main unchanged; neither -> hold.
//   SKID : down_fire -> FULL, main<=skid; else hold (no input accepted).
// - SKID_EN=0: up_ready_o = !down_valid_o | down_ready_i; only EMPTY/FULL; skid regs not built.
// - Ordering: payloads exit strictly in acceptance order; no payload dropped or duplicated except by flush.
// - Hold: while not draining, main/skid data hold value exactly (stall behaviour of the old latch).
// - Flush priority: rst_i > flush_i > handshake. flush_i=1: next state EMPTY, main and skid data <=0,
//   down_valid_o<=0; an up_fire in the flush cycle is consumed and discarded; a down_fire in the same
//   cycle still counts as delivered downstream. up_ready_o=1 the cycle after flush.
// - Stall counter: +1 each cycle down_valid_o & !down_ready_i; saturates at 2**CNT_W-1 (no wrap);
//   clr_cnt_i forces 0 and wins over increment same cycle; flush_i does not clear it.
// - Reset asserted mid-transfer: all entries lost, outputs to reset values immediately (async).
// - No X on outputs after reset; down_data_o=0 whenever down_valid_o=0 following reset/flush.
// TESTING
// - Pass-through: down_ready_i=1, send 0x1,0x2,0x3 back-to-back -> down_data_o 0x1,0x2,0x3 on
//   cycles 1,2,3 after first up_fire, up_ready_o stays 1, stall_cnt_o=0.
// - Skid fill: down_ready_i=0, send A,B,C -> A,B accepted, occ_o=2, up_ready_o=0 next cycle, C held
//   upstream; release down_ready_i -> outputs A,B,C in order, none lost.
// - Flush: occ_o=2 with A,B, assert flush_i with up_valid_i=1 data D -> next cycle down_valid_o=0,
//   down_data_o=0, occ_o=0, D never appears.
// - Counter: down_valid_o=1, down_ready_i=0 for 20 cycles with CNT_W=4 -> stall_cnt_o=15 (saturated);
//   clr_cnt_i together with a stall cycle -> 0.
// - SKID_EN=0: down_ready_i=0 while full -> up_ready_o=0 same cycle; down_ready_i=1 with up_valid_i=1 ->
//   simultaneous exit/entry, occ_o stays 1.
// - Async reset mid-stream at a non-clock edge -> down_valid_o, occ_o, stall_cnt_o=0 before next edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Elastic pipeline-stage register with a valid/ready handshake on both sides.
// It holds an opaque payload between two CPU pipeline stages (first use is
// EXE->MEM). With SKID_EN=1 a second (skid) entry lets up_ready_o come
// straight from a flop. With SKID_EN=0 the stage has a single entry and a
// combinational up_ready_o.
//
// Ports
//   clk_i, rst_i   clock (rising edge), asynchronous active-high reset
//   flush_i        synchronous kill of every held entry
//   up_valid_i     upstream payload valid
//   up_ready_o     stage can accept a payload this cycle
//   up_data_i      upstream payload
//   down_valid_o   main entry holds a valid payload
//   down_ready_i   downstream takes the main entry this cycle
//   down_data_o    main entry payload
//   clr_cnt_i      synchronous clear of the stall counter
//   stall_cnt_o    saturating count of cycles with valid & !ready downstream
//   occ_o          number of entries held (0, 1, 2)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int DATA_W  = 160,
   parameter bit SKID_EN = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              up_valid_i,
   output logic              up_ready_o,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              down_valid_o,
   input  logic              down_ready_i,
   output logic [DATA_W-1:0] down_data_o,
   input  logic              clr_cnt_i,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [1:0]        occ_o
);

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mainData_q, mainData_d;
   logic [DATA_W-1:0] skidData_q;
   logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
   logic              upReady;
   logic              upFire;
   logic              downFire;

   assign down_valid_o = (state_q != EMPTY);
   assign down_data_o  = mainData_q;
   assign stall_cnt_o  = stallCnt_q;
   assign occ_o        = state_q;
   assign up_ready_o   = upReady;
   assign upFire       = up_valid_i & upReady;
   assign downFire     = down_valid_o & down_ready_i;

   // Next-state and main-entry update.
   // A drain to EMPTY clears the main entry, so the payload reads zero
   // whenever the stage is empty. Flush overrides the handshake. An upstream
   // payload accepted in the flush cycle is dropped.
   always_comb begin
      state_d    = state_q;
      mainData_d = mainData_q;
      case (state_q)
         EMPTY: begin
            if (upFire) begin
               state_d    = FULL;
               mainData_d = up_data_i;
            end
         end
         FULL: begin
            if (upFire && downFire) begin
               mainData_d = up_data_i;
            end else if (downFire) begin
               state_d    = EMPTY;
               mainData_d = '0;
            end else if (upFire && SKID_EN) begin
               state_d = SKID;
            end
         end
         SKID: begin
            if (downFire) begin
               state_d    = FULL;
               mainData_d = skidData_q;
            end
         end
         default: begin
            state_d    = EMPTY;
            mainData_d = '0;
         end
      endcase
      if (flush_i) begin
         state_d    = EMPTY;
         mainData_d = '0;
      end
   end

   // Stall counter.
   // The counter saturates instead of wrapping. A clear wins over an
   // increment in the same cycle. Flush leaves the count alone.
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (clr_cnt_i) begin
         stallCnt_d = '0;
      end else if (down_valid_o && !down_ready_i && (stallCnt_q != CntMax)) begin
         stallCnt_d = stallCnt_q + CntOne;
      end
   end

   // Main stage state.
   // Everything resets to empty at once; the reset is asynchronous.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= EMPTY;
         mainData_q <= '0;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mainData_q <= mainData_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   generate
      if (SKID_EN) begin : genSkid
         logic              upReady_q;
         logic [DATA_W-1:0] skidData_r;

         // Skid entry and registered ready.
         // Ready is computed one cycle ahead from the next state. The skid
         // entry fills only when a payload arrives while the main entry is
         // stalled.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               upReady_q  <= 1'b1;
               skidData_r <= '0;
            end else begin
               upReady_q <= (state_d != SKID);
               if (flush_i) begin
                  skidData_r <= '0;
               end else if ((state_q == FULL) && upFire && !downFire) begin
                  skidData_r <= up_data_i;
               end
            end
         end

         assign upReady    = upReady_q;
         assign skidData_q = skidData_r;
      end else begin : genNoSkid
         // A single entry accepts when it is empty or draining this cycle.
         assign upReady    = !down_valid_o | down_ready_i;
         assign skidData_q = '0;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// Directed bench for pipe_stage_skid. It drives one skid instance and one
// single-entry instance with hand-computed expected values. Both instances
// use an 8-bit payload and a 4-bit stall counter.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         checkCount = 0;
   int         errorCount = 0;

   logic       aFlush = 1'b0, aUpValid = 1'b0, aDownReady = 1'b0, aClrCnt = 1'b0;
   logic [7:0] aUpData = 8'h00;
   logic       aUpReady, aDownValid;
   logic [7:0] aDownData;
   logic [3:0] aStallCnt;
   logic [1:0] aOcc;

   logic       bUpValid = 1'b0, bDownReady = 1'b0;
   logic [7:0] bUpData = 8'h00;
   logic       bUpReady, bDownValid;
   logic [7:0] bDownData;
   logic [3:0] bStallCnt;
   logic [1:0] bOcc;

   pipe_stage_skid #(.DATA_W(8), .SKID_EN(1'b1), .CNT_W(4)) dutSkid (
      .clk_i(clk), .rst_i(rst), .flush_i(aFlush),
      .up_valid_i(aUpValid), .up_ready_o(aUpReady), .up_data_i(aUpData),
      .down_valid_o(aDownValid), .down_ready_i(aDownReady), .down_data_o(aDownData),
      .clr_cnt_i(aClrCnt), .stall_cnt_o(aStallCnt), .occ_o(aOcc)
   );

   pipe_stage_skid #(.DATA_W(8), .SKID_EN(1'b0), .CNT_W(4)) dutNoSkid (
      .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
      .up_valid_i(bUpValid), .up_ready_o(bUpReady), .up_data_i(bUpData),
      .down_valid_o(bDownValid), .down_ready_i(bDownReady), .down_data_o(bDownData),
      .clr_cnt_i(1'b0), .stall_cnt_o(bStallCnt), .occ_o(bOcc)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value and count it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive the upstream and downstream handshake of the skid instance.
   task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
      aUpValid   = valid;
      aUpData    = data;
      aDownReady = ready;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      rst = 1'b0;
      checkOutput("rstValid", aDownValid, 0);
      checkOutput("rstData", aDownData, 0);
      checkOutput("rstOcc", aOcc, 0);
      checkOutput("rstReady", aUpReady, 1);
      checkOutput("rstCnt", aStallCnt, 0);
      checkOutput("rstReadyB", bUpReady, 1);

      $display("[TB] pass-through");
      applyStimulus(1'b1, 8'h01, 1'b1);
      tick();
      checkOutput("ptData1", aDownData, 8'h01);
      checkOutput("ptReady1", aUpReady, 1);
      applyStimulus(1'b1, 8'h02, 1'b1);
      tick();
      checkOutput("ptData2", aDownData, 8'h02);
      checkOutput("ptReady2", aUpReady, 1);
      applyStimulus(1'b1, 8'h03, 1'b1);
      tick();
      checkOutput("ptData3", aDownData, 8'h03);
      checkOutput("ptValid3", aDownValid, 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      tick();
      checkOutput("ptDrained", aDownValid, 0);
      checkOutput("ptCnt", aStallCnt, 0);

      $display("[TB] skid fill");
      applyStimulus(1'b1, 8'hA1, 1'b0);
      tick();
      checkOutput("sfOccA", aOcc, 1);
      checkOutput("sfDataA", aDownData, 8'hA1);
      applyStimulus(1'b1, 8'hB2, 1'b0);
      tick();
      checkOutput("sfOccB", aOcc, 2);
      checkOutput("sfReadyB", aUpReady, 0);
      checkOutput("sfHoldA", aDownData, 8'hA1);
      applyStimulus(1'b1, 8'hC3, 1'b0);
      tick();
      checkOutput("sfOccC", aOcc, 2);
      checkOutput("sfHoldA2", aDownData, 8'hA1);
      checkOutput("sfCnt", aStallCnt, 2);
      applyStimulus(1'b1, 8'hC3, 1'b1);
      tick();
      checkOutput("sfOutB", aDownData, 8'hB2);
      checkOutput("sfOccAfterB", aOcc, 1);
      checkOutput("sfReadyAfterB", aUpReady, 1);
      tick();
      checkOutput("sfOutC", aDownData, 8'hC3);
      applyStimulus(1'b0, 8'h00, 1'b1);
      tick();
      checkOutput("sfEmpty", aDownValid, 0);

      $display("[TB] flush");
      aClrCnt = 1'b1;
      tick();
      aClrCnt = 1'b0;
      applyStimulus(1'b1, 8'h11, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h22, 1'b0);
      tick();
      checkOutput("flOccPre", aOcc, 2);
      applyStimulus(1'b1, 8'hDD, 1'b0);
      aFlush = 1'b1;
      tick();
      aFlush = 1'b0;
      checkOutput("flValid", aDownValid, 0);
      checkOutput("flData", aDownData, 0);
      checkOutput("flOcc", aOcc, 0);
      checkOutput("flReady", aUpReady, 1);
      checkOutput("flCntKept", aStallCnt, 2);
      applyStimulus(1'b0, 8'h00, 1'b1);
      tick();
      checkOutput("flNoD", aDownValid, 0);

      $display("[TB] stall counter");
      applyStimulus(1'b1, 8'h55, 1'b0);
      aClrCnt = 1'b1;
      tick();
      aClrCnt = 1'b0;
      checkOutput("cnClr0", aStallCnt, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) tick();
      checkOutput("cnSat", aStallCnt, 15);
      aClrCnt = 1'b1;
      tick();
      aClrCnt = 1'b0;
      checkOutput("cnClrWins", aStallCnt, 0);
      tick();
      checkOutput("cnResume", aStallCnt, 1);

      $display("[TB] async reset");
      #3;
      rst = 1'b1;
      #1;
      checkOutput("arValid", aDownValid, 0);
      checkOutput("arOcc", aOcc, 0);
      checkOutput("arCnt", aStallCnt, 0);
      checkOutput("arData", aDownData, 0);
      #1;
      rst = 1'b0;
      tick();
      checkOutput("arStillEmpty", aDownValid, 0);

      $display("[TB] single entry");
      bUpValid   = 1'b1;
      bUpData    = 8'h31;
      bDownReady = 1'b0;
      #1;
      checkOutput("nsReadyEmpty", bUpReady, 1);
      tick();
      checkOutput("nsData31", bDownData, 8'h31);
      checkOutput("nsReadyFull", bUpReady, 0);
      checkOutput("nsOcc1", bOcc, 1);
      bUpData = 8'h32;
      tick();
      checkOutput("nsHold31", bDownData, 8'h31);
      checkOutput("nsCnt", bStallCnt, 1);
      bDownReady = 1'b1;
      #1;
      checkOutput("nsReadyDrain", bUpReady, 1);
      tick();
      checkOutput("nsData32", bDownData, 8'h32);
      checkOutput("nsOccSwap", bOcc, 1);
      bUpValid = 1'b0;
      tick();
      checkOutput("nsEmpty", bDownValid, 0);
      checkOutput("nsOcc0", bOcc, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
